fetch_sequencer: RTL and testbench

//  Drives the 6-bit instruction address into cpu. Takes back cpu's pc_out (pc+2) and its 16-bit result.

---
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Initiator side of the cpu pc/pc_out/out interface: steps pc from START_PC to END_PC and
// logs each result in a show-ahead trace FIFO. Define TRACE_PC_EN to also log the pc of each entry.
module fetch_sequencer #(
  parameter int              PC_W        = 6,
  parameter int              DATA_W      = 16,
  parameter logic [PC_W-1:0] START_PC    = '0,
  parameter logic [PC_W-1:0] END_PC      = PC_W'(62),
  parameter int              TRACE_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           stall,
  output logic [PC_W-1:0]                pc,
  input  logic [PC_W-1:0]                pc_next,
  input  logic [DATA_W-1:0]              result,
  output logic                           running,
  output logic                           done,
  output logic                           err,
  input  logic                           trace_rd_en,
  output logic [DATA_W-1:0]              trace_rd_data,
  output logic [PC_W-1:0]                trace_rd_pc,
  output logic                           trace_empty,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count
);

  localparam int PTR_W = $clog2(TRACE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_nxt;
  logic              err_nxt;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              full, space, push, pop;

  assign full        = (trace_count == CNT_W'(TRACE_DEPTH));
  assign trace_empty = (trace_count == '0);
  // A pop in the same cycle frees the slot the push needs.
  assign space       = !full || trace_rd_en;
  assign pop         = trace_rd_en && !trace_empty;
  assign push        = (state == S_RUN) && !stall && space;

  assign running = (state == S_RUN) || (state == S_HOLD);
  assign done    = (state == S_DONE);

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    err_nxt   = err;
    unique case (state)
      S_IDLE: if (start) begin
        state_nxt = S_RUN;
        pc_nxt    = START_PC;
      end
      S_RUN: begin
        if (push) begin
          if (pc == END_PC) begin
            state_nxt = S_DONE;
          end else if (pc_next[0]) begin
            err_nxt   = 1'b1;
            state_nxt = S_DONE;
          end else begin
            pc_nxt = pc_next;
          end
        end else begin
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: if (!stall && space) state_nxt = S_RUN;
      S_DONE: if (start) begin
        state_nxt = S_RUN;
        pc_nxt    = START_PC;
        err_nxt   = 1'b0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      pc    <= START_PC;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      err   <= err_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      trace_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   trace_count <= trace_count + 1'b1;
        2'b01:   trace_count <= trace_count - 1'b1;
        default: trace_count <= trace_count;
      endcase
    end
  end

  // NOTE: storage is not reset; the empty flag masks stale contents, which keeps it plain RAM.
  logic [DATA_W-1:0] mem_data [TRACE_DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_data[wr_ptr] <= result;
  end

  assign trace_rd_data = trace_empty ? '0 : mem_data[rd_ptr];

`ifdef TRACE_PC_EN
  logic [PC_W-1:0] mem_pc [TRACE_DEPTH];

  always_ff @(posedge clk) begin
    if (push) mem_pc[wr_ptr] <= pc;
  end

  assign trace_rd_pc = trace_empty ? '0 : mem_pc[rd_ptr];
`else
  assign trace_rd_pc = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: dut_a ends at pc 6, dut_b runs to pc 62 to exercise FIFO
// backpressure. A small combinational cpu model supplies pc+2 and a pc-derived result.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  logic        a_start = 0, a_stall = 0, a_rd_en = 0, a_bad_en = 0;
  logic [5:0]  a_pc, a_pc_next, a_rd_pc;
  logic [15:0] a_result, a_rd_data;
  logic        a_running, a_done, a_err, a_empty;
  logic [3:0]  a_count;

  logic        b_start = 0, b_stall = 0, b_rd_en = 0;
  logic [5:0]  b_pc, b_pc_next, b_rd_pc;
  logic [15:0] b_result, b_rd_data;
  logic        b_running, b_done, b_err, b_empty;
  logic [3:0]  b_count;

  always #5 clk = ~clk;

  function automatic logic [15:0] res_of(input logic [5:0] p);
    return 16'h5A00 ^ {p, p[3:0], p};
  endfunction

  assign a_pc_next = (a_bad_en && a_pc == 6'd2) ? 6'd3 : a_pc + 6'd2;
  assign a_result  = res_of(a_pc);
  assign b_pc_next = b_pc + 6'd2;
  assign b_result  = res_of(b_pc);

  fetch_sequencer #(.END_PC(6'd6)) dut_a (
    .clk(clk), .reset(reset), .start(a_start), .stall(a_stall),
    .pc(a_pc), .pc_next(a_pc_next), .result(a_result),
    .running(a_running), .done(a_done), .err(a_err),
    .trace_rd_en(a_rd_en), .trace_rd_data(a_rd_data), .trace_rd_pc(a_rd_pc),
    .trace_empty(a_empty), .trace_count(a_count)
  );

  fetch_sequencer #(.END_PC(6'd62)) dut_b (
    .clk(clk), .reset(reset), .start(b_start), .stall(b_stall),
    .pc(b_pc), .pc_next(b_pc_next), .result(b_result),
    .running(b_running), .done(b_done), .err(b_err),
    .trace_rd_en(b_rd_en), .trace_rd_data(b_rd_data), .trace_rd_pc(b_rd_pc),
    .trace_empty(b_empty), .trace_count(b_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_head_pc(input string tag, input logic [5:0] got, input logic [5:0] p);
`ifdef TRACE_PC_EN
    check(tag, 32'(got), 32'(p));
`else
    check(tag, 32'(got), 32'd0);
`endif
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1;
    // 1. reset
    reset = 1;
    step();
    step();
    reset = 0;
    check("rst_pc", 32'(a_pc), 32'd0);
    check("rst_running", 32'(a_running), 32'd0);
    check("rst_done", 32'(a_done), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_empty", 32'(a_empty), 32'd1);
    check("rst_count", 32'(a_count), 32'd0);
    check("rst_rd_data", 32'(a_rd_data), 32'd0);
    check("rst_b_empty", 32'(b_empty), 32'd1);

    // 2. short run 0..6 with a pop every cycle
    a_start = 1;
    step();
    a_start = 0;
    check("t2_pc0", 32'(a_pc), 32'd0);
    check("t2_running", 32'(a_running), 32'd1);
    a_rd_en = 1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("t2_pc_%0d", k), 32'(a_pc), (k < 4) ? 32'(2 * k) : 32'd6);
      check($sformatf("t2_head_%0d", k), 32'(a_rd_data), 32'(res_of(6'(2 * (k - 1)))));
      check_head_pc($sformatf("t2_head_pc_%0d", k), a_rd_pc, 6'(2 * (k - 1)));
    end
    check("t2_done", 32'(a_done), 32'd1);
    check("t2_running_end", 32'(a_running), 32'd0);
    step();
    check("t2_drained", 32'(a_empty), 32'd1);

    // 3. stall for 3 cycles at pc 4
    a_start = 1;
    step();
    a_start = 0;
    step();
    step();
    check("t3_pc4", 32'(a_pc), 32'd4);
    a_stall = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check($sformatf("t3_stall_pc_%0d", k), 32'(a_pc), 32'd4);
      check($sformatf("t3_stall_run_%0d", k), 32'(a_running), 32'd1);
    end
    check("t3_no_push", 32'(a_count), 32'd0);
    a_stall = 0;
    step();
    check("t3_hold_exit_pc", 32'(a_pc), 32'd4);
    step();
    check("t3_resume_pc6", 32'(a_pc), 32'd6);
    check("t3_head4", 32'(a_rd_data), 32'(res_of(6'd4)));
    step();
    check("t3_done", 32'(a_done), 32'd1);
    step();
    check("t3_drained", 32'(a_empty), 32'd1);
    a_rd_en = 0;

    // 5. misaligned pc_next at pc 2
    a_bad_en = 1;
    a_start = 1;
    step();
    a_start = 0;
    step();
    check("t5_pc2", 32'(a_pc), 32'd2);
    step();
    check("t5_err", 32'(a_err), 32'd1);
    check("t5_done", 32'(a_done), 32'd1);
    check("t5_pc_frozen", 32'(a_pc), 32'd2);
    check("t5_count", 32'(a_count), 32'd2);
    check("t5_head0", 32'(a_rd_data), 32'(res_of(6'd0)));
    a_rd_en = 1;
    step();
    a_rd_en = 0;
    check("t5_head2", 32'(a_rd_data), 32'(res_of(6'd2)));
    check_head_pc("t5_head2_pc", a_rd_pc, 6'd2);
    step();
    check("t5_err_sticky", 32'(a_err), 32'd1);
    a_bad_en = 0;
    a_start = 1;
    step();
    a_start = 0;
    check("t5_err_cleared", 32'(a_err), 32'd0);
    check("t5_restart_pc", 32'(a_pc), 32'd0);
    check("t5_restart_run", 32'(a_running), 32'd1);

    // 4. backpressure: no pops, start held high (ignored once running)
    b_start = 1;
    step();
    for (int k = 0; k < 8; k++) step();
    b_start = 0;
    check("t4_pc16", 32'(b_pc), 32'd16);
    check("t4_full", 32'(b_count), 32'd8);
    step();
    step();
    check("t4_held_pc", 32'(b_pc), 32'd16);
    check("t4_held_count", 32'(b_count), 32'd8);
    check("t4_held_running", 32'(b_running), 32'd1);
    b_rd_en = 1;
    step();
    b_rd_en = 0;
    check("t4_pop_count", 32'(b_count), 32'd7);
    check("t4_pop_pc", 32'(b_pc), 32'd16);
    step();
    check("t4_adv_pc", 32'(b_pc), 32'd18);
    check("t4_adv_count", 32'(b_count), 32'd8);
    step();
    check("t4_held_again", 32'(b_pc), 32'd18);
    b_stall = 1;
    b_rd_en = 1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t4_drain_%0d", k), 32'(b_rd_data), 32'(res_of(6'(2 + 2 * k))));
      check_head_pc($sformatf("t4_drain_pc_%0d", k), b_rd_pc, 6'(2 + 2 * k));
      step();
    end
    check("t4_drained", 32'(b_empty), 32'd1);
    b_rd_en = 0;

    // 6. reset in the middle of a run at pc 8
    reset = 1;
    step();
    reset = 0;
    b_stall = 0;
    b_start = 1;
    step();
    b_start = 0;
    for (int k = 0; k < 4; k++) step();
    check("t6_pc8", 32'(b_pc), 32'd8);
    check("t6_count4", 32'(b_count), 32'd4);
    reset = 1;
    step();
    reset = 0;
    check("t6_pc", 32'(b_pc), 32'd0);
    check("t6_running", 32'(b_running), 32'd0);
    check("t6_empty", 32'(b_empty), 32'd1);
    check("t6_count", 32'(b_count), 32'd0);
    check("t6_rd_data", 32'(b_rd_data), 32'd0);
    step();
    check("t6_stays_idle", 32'(b_pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
